gray_counter: RTL and testbench

- Parametrised N-bit up/down counter that keeps a binary and a Gray-coded view of the same count, both registered.
- Successor to the combinational bin/gray converters. It adds a clock, enable, direction, a parallel load in Gray code, a terminal-count flag and a wrap pulse.
- Used as a pointer or sequence source wherever a Gray value crosses a domain boundary. Examples: async FIFO read/write pointers, encoder position tracking.

---
 rtl/gray_counter.sv | 104 ++++++++++
 tb/tb_gray_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: N-bit up/down counter keeping a registered binary count
// and a registered Gray copy of the same value. Intended as a pointer or
// sequence source whose Gray view crosses a clock domain boundary.
//
// Build option: define GRAY_COUNTER_SAT_EN to make the counter saturate
// at all-ones / zero instead of wrapping. In that build o_wrap is tied to 0.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst     asynchronous active-high reset
//   i_en      count enable, one step per cycle while high
//   i_up      direction: 1 = increment, 0 = decrement
//   i_load    synchronous parallel load strobe (wins over i_en)
//   i_load_G  Gray-coded value to load
//   o_B       registered count, binary
//   o_G       registered count, Gray (always gray(o_B))
//   o_tc      combinational terminal count for the current i_up
//   o_wrap    registered one-cycle pulse following a wrap step
module gray_counter #(
  parameter int            N         = 8,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_load,
  input  logic [N-1:0] i_load_G,
  output logic [N-1:0] o_B,
  output logic [N-1:0] o_G,
  output logic         o_tc,
  output logic         o_wrap
);

  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RESET_G   = RESET_VAL ^ (RESET_VAL >> 1);

  logic [N-1:0] b_q, g_q;
  logic         wrap_q;

  logic [N-1:0] load_b;   // binary image of i_load_G
  logic [N-1:0] step_b;   // next binary value for a count step
  logic [N-1:0] step_g;
  logic         at_max, at_min, at_end;
  logic         wrap_step;

  // Gray to binary: bit k is the XOR of all Gray bits from k up to the MSB.
  // Written as a prefix reduction so no bit depends on another output bit.
  always_comb begin
    load_b = '0;
    for (int k = 0; k < N; k++) begin
      load_b[k] = ^(i_load_G >> k);
    end
  end

  assign at_max = (b_q == {N{1'b1}});
  assign at_min = (b_q == '0);
  assign at_end = i_up ? at_max : at_min;

  // Terminal count is purely combinational so it tracks i_up even in reset.
  assign o_tc = at_end;

`ifdef GRAY_COUNTER_SAT_EN
  // Saturating build: at the end point the step holds the current value,
  // and there is never a wrap to report.
  always_comb begin
    step_b = i_up ? (b_q + ONE) : (b_q - ONE);
    if (at_end) step_b = b_q;
  end
  assign wrap_step = 1'b0;
`else
  always_comb begin
    step_b = i_up ? (b_q + ONE) : (b_q - ONE);
  end
  assign wrap_step = at_end;
`endif

  assign step_g = step_b ^ (step_b >> 1);

  // Priority: reset > load > count > hold. o_wrap is cleared by anything
  // other than a wrapping count step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      b_q    <= RESET_VAL;
      g_q    <= RESET_G;
      wrap_q <= 1'b0;
    end else if (i_load) begin
      b_q    <= load_b;
      g_q    <= i_load_G;
      wrap_q <= 1'b0;
    end else if (i_en) begin
      b_q    <= step_b;
      g_q    <= step_g;
      wrap_q <= wrap_step;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign o_B    = b_q;
  assign o_G    = g_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_up, i_load;
  logic [3:0] i_load_G;
  logic [3:0] o_B, o_G;
  logic       o_tc, o_wrap;

  int total = 0;
  int bad   = 0;

  // Gray codes for binary 0..15, written out by hand.
  logic [3:0] gt [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter #(.N(4), .RESET_VAL(4'd5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_up(i_up),
    .i_load(i_load), .i_load_G(i_load_G),
    .o_B(o_B), .o_G(o_G), .o_tc(o_tc), .o_wrap(o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev_g;
    logic [3:0] eb;
    i_rst = 1'b1; i_en = 1'b0; i_up = 1'b0; i_load = 1'b0; i_load_G = 4'h0;
    #1;
    chk("rst_b",    o_B,    32'h5);
    chk("rst_g",    o_G,    32'h7);
    chk("rst_wrap", o_wrap, 32'h0);
    chk("rst_tc",   o_tc,   32'h0);
    #6 i_rst = 1'b0;

    // a couple of up steps, then reset mid-cycle without a clock edge
    i_en = 1'b1; i_up = 1'b1;
    step();
    chk("pre_b1", o_B, 32'h6);
    chk("pre_g1", o_G, 32'h5);
    step();
    chk("pre_b2", o_B, 32'h7);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_b",    o_B,    32'h5);
    chk("mid_rst_g",    o_G,    32'h7);
    chk("mid_rst_wrap", o_wrap, 32'h0);
    i_rst = 1'b0;

    // load zero (Gray 0000) with enable high; load wins
    i_load = 1'b1; i_load_G = 4'h0;
    step();
    i_load = 1'b0;
    chk("ld0_b", o_B, 32'h0);
    chk("ld0_g", o_G, 32'h0);
    chk("tc_up_at0", o_tc, 32'h0);
    i_up = 1'b0; #1;
    chk("tc_dn_at0", o_tc, 32'h1);
    i_up = 1'b1;

    // full up walk of 16 steps
    prev_g = o_G;
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef GRAY_COUNTER_SAT_EN
      eb = (k == 16) ? 4'hF : k[3:0];
      chk("up_wrap", o_wrap, 32'h0);
      if (k < 16) chk("up_onebit", $countones(prev_g ^ o_G), 32'd1);
`else
      eb = k[3:0];
      chk("up_wrap", o_wrap, (k == 16) ? 32'h1 : 32'h0);
      chk("up_onebit", $countones(prev_g ^ o_G), 32'd1);
`endif
      chk("up_b",  o_B,  {28'h0, eb});
      chk("up_g",  o_G,  {28'h0, gt[eb]});
      chk("up_tc", o_tc, (eb == 4'hF) ? 32'h1 : 32'h0);
      prev_g = o_G;
    end
    i_en = 1'b0;
    step();
    chk("up_hold_wrap", o_wrap, 32'h0);

    // down wrap from zero
    i_load = 1'b1; i_load_G = 4'h0;
    step();
    i_load = 1'b0; i_up = 1'b0; i_en = 1'b1;
    #1;
    chk("dn_tc", o_tc, 32'h1);
    step();
`ifdef GRAY_COUNTER_SAT_EN
    chk("dn_b",    o_B,    32'h0);
    chk("dn_g",    o_G,    32'h0);
    chk("dn_wrap", o_wrap, 32'h0);
`else
    chk("dn_b",    o_B,    32'hF);
    chk("dn_g",    o_G,    32'h8);
    chk("dn_wrap", o_wrap, 32'h1);
`endif
    i_en = 1'b0;
    step();
    chk("dn_hold_wrap", o_wrap, 32'h0);

    // load priority over enable
    i_load = 1'b1; i_load_G = 4'hD; i_en = 1'b1; i_up = 1'b1;
    step();
    i_load = 1'b0;
    chk("ldp_g",    o_G,    32'hD);
    chk("ldp_b",    o_B,    32'h9);
    chk("ldp_wrap", o_wrap, 32'h0);

    // direction change and hold from 0110 (Gray 0101)
    i_load = 1'b1; i_load_G = 4'h5; i_en = 1'b0;
    step();
    i_load = 1'b0;
    chk("dir_ld_b", o_B, 32'h6);
    i_en = 1'b1; i_up = 1'b1;
    step();
    chk("dir_b1", o_B, 32'h7); chk("dir_g1", o_G, 32'h4);
    step();
    chk("dir_b2", o_B, 32'h8); chk("dir_g2", o_G, 32'hC);
    i_en = 1'b0;
    step();
    chk("dir_b3", o_B, 32'h8); chk("dir_g3", o_G, 32'hC);
    i_en = 1'b1; i_up = 1'b0;
    step();
    chk("dir_b4", o_B, 32'h7); chk("dir_g4", o_G, 32'h4);

    // top end behaviour from 1111 (Gray 1000) counting up
    i_load = 1'b1; i_load_G = 4'h8; i_en = 1'b0;
    step();
    i_load = 1'b0; i_en = 1'b1; i_up = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_b",    o_B,    32'hF);
      chk("sat_g",    o_G,    32'h8);
      chk("sat_wrap", o_wrap, 32'h0);
      chk("sat_tc",   o_tc,   32'h1);
    end
`else
    step();
    chk("top_b1",    o_B,    32'h0);
    chk("top_g1",    o_G,    32'h0);
    chk("top_wrap1", o_wrap, 32'h1);
    step();
    chk("top_b2",    o_B,    32'h1);
    chk("top_g2",    o_G,    32'h1);
    chk("top_wrap2", o_wrap, 32'h0);
`endif
    i_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
